// File: rtl/omem_drain_if.sv
// Bundles the tile-controller, host-readout and OMEM-port signals of the drain controller.
// master is the controller side; slave is the environment (tile controller, host, OMEM).
interface omem_drain_if;
    logic       START_CALC;
    logic       ACC;
    logic [3:0] ODST_BASE;
    logic [2:0] ROWS;
    logic       HOST_RE;
    logic [3:0] HOST_ADDR;
    logic [3:0] O_ADDR;
    logic       O_RE;
    logic       O_WE;
    logic [1:0] ROW_SEL;
    logic       ADD_EN;
    logic       HOST_GNT;
    logic       Tile_Done;
    logic       BUSY;
    logic       OVR;

    modport master (
        input  START_CALC, ACC, ODST_BASE, ROWS, HOST_RE, HOST_ADDR,
        output O_ADDR, O_RE, O_WE, ROW_SEL, ADD_EN, HOST_GNT, Tile_Done, BUSY, OVR
    );

    modport slave (
        output START_CALC, ACC, ODST_BASE, ROWS, HOST_RE, HOST_ADDR,
        input  O_ADDR, O_RE, O_WE, ROW_SEL, ADD_EN, HOST_GNT, Tile_Done, BUSY, OVR
    );
endinterface

// File: rtl/omem_drain_ctrl.sv
// OMEM write-back sequencer: waits LAT cycles after each tile's compute start, writes 1-4 rows
// (optionally read-modify-write), pulses Tile_Done, and hands the OMEM port to the host between tiles.
module omem_drain_ctrl #(
    parameter int LAT = 7
) (
    input  logic          CLK,
    input  logic          RSTN,
    omem_drain_if.master  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;

    // WAIT is entered at T0+1 and counts down to zero, so XFER starts exactly at T0+LAT.
    localparam logic [3:0] LAT_LOAD = (LAT >= 2) ? 4'(LAT - 2) : 4'd0;
    localparam bit         LAT_ONE  = (LAT == 1);

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic [1:0] row_reg, row_next;
    logic       phase_reg, phase_next;
    logic       start_prev_reg;
    logic       acc_reg;
    logic [3:0] base_reg;
    logic [2:0] rows_reg;
    logic       ovr_reg;

    logic       t0;
    logic [2:0] rows_clamped;
    logic       last_row;

    assign t0           = bus.START_CALC && !start_prev_reg;
    assign rows_clamped = (bus.ROWS > 3'd4) ? 3'd4 : bus.ROWS;
    assign last_row     = ({1'b0, row_reg} == (rows_reg - 3'd1));

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            row_reg        <= 2'd0;
            phase_reg      <= 1'b0;
            start_prev_reg <= 1'b0;
            acc_reg        <= 1'b0;
            base_reg       <= 4'd0;
            rows_reg       <= 3'd0;
            ovr_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            row_reg        <= row_next;
            phase_reg      <= phase_next;
            start_prev_reg <= bus.START_CALC;
            if (t0 && state_reg == IDLE) begin
                acc_reg  <= bus.ACC;
                base_reg <= bus.ODST_BASE;
                rows_reg <= rows_clamped;
            end
            if (t0 && state_reg != IDLE) begin
                ovr_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        row_next      = row_reg;
        phase_next    = phase_reg;
        bus.O_ADDR    = 4'd0;
        bus.O_RE      = 1'b0;
        bus.O_WE      = 1'b0;
        bus.ROW_SEL   = 2'd0;
        bus.ADD_EN    = 1'b0;
        bus.HOST_GNT  = 1'b0;
        bus.Tile_Done = 1'b0;

        unique case (state_reg)
            IDLE: begin
                bus.HOST_GNT = bus.HOST_RE;
                bus.O_RE     = bus.HOST_RE;
                bus.O_ADDR   = bus.HOST_ADDR;
                row_next     = 2'd0;
                phase_next   = 1'b0;
                if (t0) begin
                    if (LAT_ONE) begin
                        state_next = (rows_clamped == 3'd0) ? DONE : XFER;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = LAT_LOAD;
                    end
                end
            end
            WAIT: begin
                bus.HOST_GNT = bus.HOST_RE;
                bus.O_RE     = bus.HOST_RE;
                bus.O_ADDR   = bus.HOST_ADDR;
                if (cnt_reg == 4'd0) begin
                    state_next = (rows_reg == 3'd0) ? DONE : XFER;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            XFER: begin
                bus.O_ADDR  = base_reg + {2'b00, row_reg};
                bus.ROW_SEL = row_reg;
                // Accumulating rows take a read phase, then the write of the summed data.
                if (acc_reg && !phase_reg) begin
                    bus.O_RE   = 1'b1;
                    phase_next = 1'b1;
                end else begin
                    bus.O_WE   = 1'b1;
                    bus.ADD_EN = acc_reg;
                    phase_next = 1'b0;
                    if (last_row) begin
                        state_next = DONE;
                    end else begin
                        row_next = row_reg + 2'd1;
                    end
                end
            end
            DONE: begin
                bus.Tile_Done = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.BUSY = (state_reg != IDLE);
    assign bus.OVR  = ovr_reg;
endmodule
